axis_demodulator: RTL and testbench



---
 rtl/axis_demod_pkg.sv | 27 ++
 rtl/axis_demod_slicer.sv | 29 ++
 rtl/axis_demodulator.sv | 107 ++++++++++
 tb/tb_axis_demodulator.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_demod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_demod_pkg
// Description : Shared constants and helpers for the hard-decision demodulator.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_demod_pkg;

  localparam int BPS_BPSK = 1;
  localparam int BPS_QPSK = 2;

  localparam int I_LSB    = 0;
  localparam int Q_LSB    = 16;
  localparam int SAMPLE_W = 16;

  // Byte lanes that hold at least one of the lowest nbits bits.
  function automatic logic [3:0] strb_from_bits(input logic [5:0] nbits);
    logic [3:0] strb;
    strb[0] = (nbits > 6'd0);
    strb[1] = (nbits > 6'd8);
    strb[2] = (nbits > 6'd16);
    strb[3] = (nbits > 6'd24);
    return strb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_demod_slicer.sv
`default_nettype none
// ============================================================================
// Module      : axis_demod_slicer
// Description : Combinational hard-decision slicer, one complex sample to BPS bits.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_demod_slicer
  import axis_demod_pkg::*;
#(
  parameter int BPS = 2
) (
  input  logic [31:0]    sample,
  output logic [BPS-1:0] symbol
);

  // Only the sign bits decide; the magnitudes are carried but not needed.
  logic w_unused_bits;
  assign w_unused_bits = ^sample;

  generate
    if (BPS == BPS_QPSK) begin : g_qpsk
      assign symbol = {sample[Q_LSB + SAMPLE_W - 1], sample[I_LSB + SAMPLE_W - 1]};
    end else begin : g_bpsk
      assign symbol = sample[I_LSB + SAMPLE_W - 1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/axis_demodulator.sv
`default_nettype none
// ============================================================================
// Module      : axis_demodulator
// Description : Slices AXI-Stream samples to BPS bits and packs them LSB-first
//               into 32-bit words, flushing partial words on tlast.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_demodulator
  import axis_demod_pkg::*;
#(
  parameter int BPS        = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic        m00_axis_aclk,
  input  logic        m00_axis_aresetn,
  input  logic [31:0] s00_axis_tdata,
  input  logic [3:0]  s00_axis_tstrb,
  input  logic        s00_axis_tlast,
  input  logic        s00_axis_tvalid,
  output logic        s00_axis_tready,
  output logic [31:0] m00_axis_tdata,
  output logic [3:0]  m00_axis_tstrb,
  output logic        m00_axis_tlast,
  output logic        m00_axis_tvalid,
  input  logic        m00_axis_tready
);

  localparam int c_SYMS  = 32 / BPS;
  localparam int c_CNT_W = $clog2(c_SYMS);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(c_SYMS - 1);

  generate
    if ((BPS != BPS_BPSK) && (BPS != BPS_QPSK)) begin : g_bad_bps
      $error("axis_demodulator: BPS must be 1 or 2");
    end
    if (DATA_WIDTH != 32) begin : g_bad_width
      $error("axis_demodulator: DATA_WIDTH must be 32");
    end
  endgenerate

  logic               w_unused_strb;
  logic [BPS-1:0]     w_symbol;
  logic               w_accept;
  logic               w_complete;
  logic [4:0]         w_pos;
  logic [5:0]         w_nbits;
  logic [31:0]        w_word;

  logic [31:0]        r_acc;
  logic [c_CNT_W-1:0] r_cnt;
  logic [31:0]        r_tdata;
  logic [3:0]         r_tstrb;
  logic               r_tlast;
  logic               r_tvalid;

  assign w_unused_strb = ^s00_axis_tstrb;

  axis_demod_slicer #(
    .BPS (BPS)
  ) u_slicer (
    .sample (s00_axis_tdata),
    .symbol (w_symbol)
  );

  assign s00_axis_tready = !r_tvalid || m00_axis_tready;
  assign w_accept        = s00_axis_tvalid && s00_axis_tready;
  assign w_complete      = w_accept && ((r_cnt == c_CNT_MAX) || s00_axis_tlast);

  // Bit position of the incoming symbol and the fill level once it lands.
  assign w_pos   = 5'(r_cnt) * 5'(BPS);
  assign w_nbits = {1'b0, w_pos} + 6'(BPS);
  assign w_word  = r_acc | (32'(w_symbol) << w_pos);

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_tdata  <= '0;
      r_tstrb  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else if (w_complete) begin
      // A completion may overwrite a word handed off on this same edge.
      r_tdata  <= w_word;
      r_tstrb  <= strb_from_bits(w_nbits);
      r_tlast  <= s00_axis_tlast;
      r_tvalid <= 1'b1;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      if (m00_axis_tready) begin
        r_tvalid <= 1'b0;
      end
      if (w_accept) begin
        r_acc <= w_word;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign m00_axis_tdata  = r_tdata;
  assign m00_axis_tstrb  = r_tstrb;
  assign m00_axis_tlast  = r_tlast;
  assign m00_axis_tvalid = r_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_axis_demodulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_demodulator
// Description : Directed self-checking bench for QPSK and BPSK demodulator builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_demodulator;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        s_tlast;
  logic        s_tvalid;
  logic        m_tready;

  logic        q_sready, q_tlast, q_tvalid;
  logic [31:0] q_tdata;
  logic [3:0]  q_tstrb;
  logic        b_sready, b_tlast, b_tvalid;
  logic [31:0] b_tdata;
  logic [3:0]  b_tstrb;

  int n_checks = 0;
  int n_fail   = 0;

  axis_demodulator #(.BPS(2), .DATA_WIDTH(32)) u_dut_qpsk (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tstrb   (s_tstrb),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tready  (q_sready),
    .m00_axis_tdata   (q_tdata),
    .m00_axis_tstrb   (q_tstrb),
    .m00_axis_tlast   (q_tlast),
    .m00_axis_tvalid  (q_tvalid),
    .m00_axis_tready  (m_tready)
  );

  axis_demodulator #(.BPS(1), .DATA_WIDTH(32)) u_dut_bpsk (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tstrb   (s_tstrb),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tready  (b_sready),
    .m00_axis_tdata   (b_tdata),
    .m00_axis_tstrb   (b_tstrb),
    .m00_axis_tlast   (b_tlast),
    .m00_axis_tvalid  (b_tvalid),
    .m00_axis_tready  (m_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] smp(input int i, input int q);
    return {q[15:0], i[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Present one beat to the selected build and return just after it is taken.
  task automatic send(input bit bpsk, input logic [31:0] d, input logic last);
    int n;
    n = 0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!(bpsk ? b_sready : q_sready) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic chk_q(input string tag, input logic [31:0] d, input logic [3:0] s, input logic l);
    chk({tag, "_valid"}, 32'(q_tvalid), 32'd1);
    chk({tag, "_data"},  q_tdata, d);
    chk({tag, "_strb"},  32'(q_tstrb), 32'(s));
    chk({tag, "_last"},  32'(q_tlast), 32'(l));
  endtask

  task automatic chk_b(input string tag, input logic [31:0] d, input logic [3:0] s, input logic l);
    chk({tag, "_valid"}, 32'(b_tvalid), 32'd1);
    chk({tag, "_data"},  b_tdata, d);
    chk({tag, "_strb"},  32'(b_tstrb), 32'(s));
    chk({tag, "_last"},  32'(b_tlast), 32'(l));
  endtask

  initial begin
    s_tdata  = '0;
    s_tstrb  = 4'hF;
    s_tlast  = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    rst_n    = 1'b0;

    // Reset state
    do_reset();
    chk("rst_q_valid", 32'(q_tvalid), 32'd0);
    chk("rst_q_data",  q_tdata, 32'h0);
    chk("rst_q_strb",  32'(q_tstrb), 32'h0);
    chk("rst_b_valid", 32'(b_tvalid), 32'd0);
    chk("rst_q_sready", 32'(q_sready), 32'd1);

    // QPSK full word: I>0, Q<0 gives symbol 2'b10 in every slot
    for (int k = 0; k < 15; k++) send(1'b0, smp(100, -100), 1'b0);
    chk("qfull_pre_valid", 32'(q_tvalid), 32'd0);
    send(1'b0, smp(100, -100), 1'b1);
    chk_q("qfull", 32'hAAAA_AAAA, 4'hF, 1'b1);
    @(posedge clk); #1;
    chk("qfull_drain", 32'(q_tvalid), 32'd0);

    // BPSK full word without tlast, then a two-symbol continuation
    do_reset();
    for (int k = 0; k < 32; k++) send(1'b1, smp((k % 2 == 0) ? -5 : 5, 0), 1'b0);
    chk_b("bfull", 32'h5555_5555, 4'hF, 1'b0);
    send(1'b1, smp(-5, 0), 1'b0);
    chk("b33_valid", 32'(b_tvalid), 32'd0);
    send(1'b1, smp(-5, 0), 1'b1);
    chk_b("b34", 32'h0000_0003, 4'b0001, 1'b1);

    // QPSK partial flush, then a one-symbol packet starting at bit 0
    do_reset();
    for (int k = 0; k < 4; k++) send(1'b0, smp(-1, -1), 1'b0);
    send(1'b0, smp(-1, -1), 1'b1);
    chk_q("qpart", 32'h0000_03FF, 4'b0011, 1'b1);
    send(1'b0, smp(-1, 1), 1'b1);
    chk_q("qone", 32'h0000_0001, 4'b0001, 1'b1);

    // Backpressure: word held with downstream stalled
    do_reset();
    m_tready = 1'b0;
    for (int k = 0; k < 16; k++) send(1'b0, smp(-1, -1), 1'b0);
    chk_q("bp", 32'hFFFF_FFFF, 4'hF, 1'b0);
    chk("bp_sready", 32'(q_sready), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_data",  q_tdata, 32'hFFFF_FFFF);
      chk("bp_hold_valid", 32'(q_tvalid), 32'd1);
    end
    m_tready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 32'(q_tvalid), 32'd0);
    // Back-to-back one-symbol words on consecutive cycles
    send(1'b0, smp(-1, -1), 1'b1);
    chk_q("b2b0", 32'h0000_0003, 4'b0001, 1'b1);
    send(1'b0, smp(1, -1), 1'b1);
    chk_q("b2b1", 32'h0000_0002, 4'b0001, 1'b1);
    send(1'b0, smp(-1, 1), 1'b1);
    chk_q("b2b2", 32'h0000_0001, 4'b0001, 1'b1);

    // Sign boundaries: zero slices to 0, most negative value to 1
    do_reset();
    for (int k = 0; k < 32; k++) send(1'b1, smp(0, 0), 1'b0);
    chk_b("bzero", 32'h0000_0000, 4'hF, 1'b0);
    for (int k = 0; k < 32; k++) send(1'b1, smp(-32768, 0), 1'b0);
    chk_b("bmin", 32'hFFFF_FFFF, 4'hF, 1'b0);

    // Asynchronous reset mid-word discards the partial accumulation
    do_reset();
    send(1'b0, smp(-1, -1), 1'b1);
    for (int k = 0; k < 7; k++) send(1'b0, smp(-1, -1), 1'b0);
    chk("pre_rst_data", q_tdata, 32'h0000_0003);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(q_tvalid), 32'd0);
    chk("arst_data",  q_tdata, 32'h0);
    chk("arst_strb",  32'(q_tstrb), 32'h0);
    chk("arst_last",  32'(q_tlast), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) send(1'b0, smp(-1, 1), 1'b0);
    chk_q("post_rst", 32'h5555_5555, 4'hF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
